// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] OPC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // One fetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input, decode handshake.
// Latency: n/a (wires only).
// Backpressure: decode stalls the stream by holding id_ready low.
interface fetch_unit_if #(
    parameter int ADDR_W = 6,
    parameter int XLEN   = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_inst;
    logic [XLEN-1:0]   id_pc;
    logic              halted;

    // Fetch unit side.
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_pc,
        output halted
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with synchronous clear.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: full when DEPTH entries held; push and pop may coincide when full.
module fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         clear,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Empty queue presents zeros rather than stale storage.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: clear wins over push/pop; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage and pointer registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, queues {pc, inst} pairs, hands them to decode.
// Latency: instruction appears on id_* the cycle after its address is driven.
// Backpressure: fetch stalls when the queue is full and decode is not accepting.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 6,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            deq, enq;
    logic            q_full, q_empty;
    fetch_entry_t    q_head;
    fetch_entry_t    new_entry;

    assign deq = bus.id_valid & bus.id_ready;
    assign enq = !bus.redirect_valid & !halted_q & (!q_full | deq);

    assign new_entry.pc   = pc_q;
    assign new_entry.inst = bus.imem_data;

    assign bus.imem_addr = pc_q[ADDR_W+1:2];
    assign bus.id_valid  = !q_empty;
    assign bus.id_inst   = q_head.inst;
    assign bus.id_pc     = q_head.pc;
    assign bus.halted    = halted_q;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (enq),
        .push_dat (new_entry),
        .pop      (deq),
        .clear    (bus.redirect_valid),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    // PC / halt next-state: redirect overrides everything, else advance on each enqueue.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc & ~XLEN'(3);
            halted_d = 1'b0;
        end else if (enq) begin
            pc_d = pc_q + XLEN'(4);
            if (bus.imem_data == OPC_ECALL) begin
                halted_d = 1'b1;
            end
        end
    end

    // PC and halt flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import rv_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(6), .XLEN(32)) bus ();

    logic [31:0] imem [64];
    assign bus.imem_data = imem[bus.imem_addr];

    fetch_unit #(
        .ADDR_W   (6),
        .XLEN     (32),
        .RESET_PC (32'h0),
        .QDEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_entry_t sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected entry for a PC, built from the bench's own memory image.
    function automatic void exp_push(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = imem[pc[7:2]];
        sb.push_back(e);
    endfunction

    // One clock: score the handshake about to happen, then advance to edge+2.
    task automatic cycle();
        fetch_entry_t e;
        #1;
        if (bus.id_valid && bus.id_ready) begin
            chk("sb_underflow", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc", bus.id_pc, e.pc);
                chk("sb_inst", bus.id_inst, e.inst);
            end
        end else if (!bus.id_valid) begin
            chk("empty_pc", bus.id_pc, 32'h0);
            chk("empty_inst", bus.id_inst, 32'h0);
        end
        @(posedge clk);
        #2;
    endtask

    // Assert reset, check it takes effect without a clock, release after one edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("rst_pc", bus.id_pc, 32'h0);
        chk("rst_inst", bus.id_inst, 32'h0);
        chk("rst_halted", {31'b0, bus.halted}, 32'd0);
        chk("rst_addr", {26'b0, bus.imem_addr}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #3;
        do_reset();

        // Streaming from reset: one new address and one delivered word every cycle.
        for (int k = 0; k < 6; k++) begin
            chk("a_addr", {26'b0, bus.imem_addr}, 32'(k));
            if (k > 0) chk("a_valid", {31'b0, bus.id_valid}, 32'd1);
            exp_push(32'(4 * k));
            cycle();
        end

        // Decode stalled from reset: queue fills, pc holds.
        bus.id_ready = 1'b0;
        do_reset();
        exp_push(32'h0);
        exp_push(32'h4);
        repeat (5) cycle();
        chk("b_addr", {26'b0, bus.imem_addr}, 32'd2);
        chk("b_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("b_head", bus.id_pc, 32'h0);
        bus.id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_push(32'(8 + 4 * k));
            cycle();
        end
        chk("b_stream_valid", {31'b0, bus.id_valid}, 32'd1);

        // Redirect with two entries queued, misaligned target.
        bus.id_ready = 1'b0;
        cycle();
        chk("c_full_valid", {31'b0, bus.id_valid}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1E;
        cycle();
        bus.redirect_valid = 1'b0;
        sb.delete();
        chk("c_flushed", {31'b0, bus.id_valid}, 32'd0);
        chk("c_addr", {26'b0, bus.imem_addr}, 32'd7);
        bus.id_ready = 1'b1;
        exp_push(32'h1C);
        cycle();
        chk("c_pc", bus.id_pc, 32'h1C);
        exp_push(32'h20);
        cycle();
        // Redirect coinciding with a dequeue of the head.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        cycle();
        bus.redirect_valid = 1'b0;
        sb.delete();
        chk("c2_empty", {31'b0, bus.id_valid}, 32'd0);
        chk("c2_addr", {26'b0, bus.imem_addr}, 32'd16);

        // ECALL at word 2 stops fetch after it is enqueued.
        imem[2] = OPC_ECALL;
        do_reset();
        exp_push(32'h0);
        exp_push(32'h4);
        exp_push(32'h8);
        cycle();
        cycle();
        chk("d_halt0", {31'b0, bus.halted}, 32'd0);
        cycle();
        chk("d_halt1", {31'b0, bus.halted}, 32'd1);
        chk("d_addr", {26'b0, bus.imem_addr}, 32'd3);
        repeat (3) cycle();
        chk("d_drained", {31'b0, bus.id_valid}, 32'd0);
        chk("d_sb_left", 32'(sb.size()), 32'd0);
        chk("d_halt_hold", {31'b0, bus.halted}, 32'd1);

        // Redirect releases the halt and restarts at word 0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("e_halt", {31'b0, bus.halted}, 32'd0);
        chk("e_addr", {26'b0, bus.imem_addr}, 32'd0);
        exp_push(32'h0);
        cycle();
        chk("e_pc", bus.id_pc, 32'h0);
        exp_push(32'h4);
        cycle();
        chk("e_pc2", bus.id_pc, 32'h4);

        // Word-address wrap at the top of memory.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFC;
        cycle();
        bus.redirect_valid = 1'b0;
        sb.delete();
        chk("f_addr63", {26'b0, bus.imem_addr}, 32'd63);
        exp_push(32'hFC);
        cycle();
        chk("f_addr0", {26'b0, bus.imem_addr}, 32'd0);
        exp_push(32'h100);
        cycle();
        chk("f_pc", bus.id_pc, 32'h100);

        // PC wrap modulo 2**32.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        bus.redirect_valid = 1'b0;
        sb.delete();
        chk("w_addr63", {26'b0, bus.imem_addr}, 32'd63);
        exp_push(32'hFFFF_FFFC);
        cycle();
        chk("w_addr0", {26'b0, bus.imem_addr}, 32'd0);
        exp_push(32'h0);
        cycle();
        chk("w_pc", bus.id_pc, 32'h0);

        // Asynchronous reset with the queue full.
        bus.id_ready = 1'b0;
        cycle();
        cycle();
        chk("g_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("g_addr", {26'b0, bus.imem_addr}, 32'd2);
        imem[2] = 32'h1000_0000 + 32'd2 * 32'h0001_0101;
        do_reset();

        // Clean restart after reset.
        bus.id_ready = 1'b1;
        exp_push(32'h0);
        exp_push(32'h4);
        exp_push(32'h8);
        repeat (4) cycle();
        chk("end_sb_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
